// File: rtl/multdiv_pkg.sv
// multdiv_pkg -- shared types and constants for the iterative multiply/divide unit.
//
// Contents:
//   state_e        FSM state encoding (IDLE, MUL, DIV, DONE)
//   WIDTH_DEFAULT  default operand/result width
//   MUL_CYCLES     iterations of the multiply datapath at the default width
//   DIV_CYCLES     iterations of the divide datapath at the default width
//   mul_cycles_f / div_cycles_f  the same latencies for an arbitrary width
//
// Configuration macro: MULTDIV_RADIX4_EN -- when defined, the multiplier
// retires two multiplier bits per cycle (radix-4 Booth), halving MUL latency.
package multdiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int WIDTH_DEFAULT = 32;

   function automatic int mul_cycles_f(input int w);
`ifdef MULTDIV_RADIX4_EN
      return w / 2;
`else
      return w;
`endif
   endfunction

   function automatic int div_cycles_f(input int w);
      return w;
   endfunction

   localparam int MUL_CYCLES = mul_cycles_f(WIDTH_DEFAULT);
   localparam int DIV_CYCLES = div_cycles_f(WIDTH_DEFAULT);

endpackage

// File: rtl/multdiv_div_core.sv
// multdiv_div_core -- unsigned restoring-division datapath, one quotient bit
// per step. The controlling FSM decides when to load and how many steps run.
//
// Ports:
//   clk_i        clock
//   load_i       capture dividend/divisor magnitudes, clear the remainder
//   step_i       perform one shift/subtract/restore iteration
//   dividend_i   dividend magnitude (unsigned)
//   divisor_i    divisor magnitude (unsigned, non-zero when stepping)
//   quot_next_o  quotient as it will be after the current step; on the final
//                step this is the complete quotient magnitude
module multdiv_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quot_next_o
);

   logic [WIDTH-1:0] rem_q, quot_q, dsr_q;
   logic [WIDTH-1:0] rem_d, quot_d;
   logic [WIDTH:0]   rem_sh, diff;

   // The dividend is shifted out of the top of the quotient register while
   // quotient bits are shifted in at the bottom.
   always_comb begin
      rem_sh = {rem_q, quot_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, dsr_q};
      if (!diff[WIDTH]) begin
         rem_d  = diff[WIDTH-1:0];
         quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_d  = rem_sh[WIDTH-1:0];
         quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk_i) begin
      if (load_i) begin
         rem_q  <= '0;
         quot_q <= dividend_i;
         dsr_q  <= divisor_i;
      end else if (step_i) begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
      end
   end

   assign quot_next_o = quot_d;

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit -- iterative signed multiply / divide unit for the execute stage.
//
// Ports:
//   clock           clock, all state changes on the rising edge
//   reset           synchronous active-high reset
//   ctrl_MULT       one-cycle start pulse for a signed multiply (wins over DIV)
//   ctrl_DIV        one-cycle start pulse for a signed divide
//   data_operandA   multiplicand / dividend, sampled only on a start cycle
//   data_operandB   multiplier / divisor, sampled only on a start cycle
//   data_result     low WIDTH bits of the product, or the quotient
//   data_exception  multiply overflow, divide-by-zero or MIN/-1 overflow
//   data_resultRDY  one-cycle completion pulse
//   busy            high from the cycle after a start through data_resultRDY
//
// Configuration macro: MULTDIV_RADIX4_EN -- radix-4 Booth multiply, WIDTH/2
// iterations instead of WIDTH (WIDTH must be even). Divide is unaffected.
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int PW        = 2 * WIDTH;
   localparam int MulCycles = mul_cycles_f(WIDTH);
   localparam int DivCycles = div_cycles_f(WIDTH);
   localparam int CntW      = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] MulLast = CntW'(MulCycles - 1);
   localparam logic [CntW-1:0] DivLast = CntW'(DivCycles - 1);
`ifdef MULTDIV_RADIX4_EN
   localparam int MW = WIDTH + 1;   // multiplier with the implicit Booth bit below LSB
`else
   localparam int MW = WIDTH;
`endif

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic signed [PW-1:0]    acc_q, mcand_q, addend, prod_next;
   logic [MW-1:0]           mplier_q;
   logic                    sign_diff_q, div_zero_q, div_ovf_q;
   logic [WIDTH-1:0]        res_q, res_d;
   logic                    exc_q, exc_d;
   logic                    load_mul, load_div, mul_step, div_step;
   logic [WIDTH-1:0]        quot_mag;

   // Product does not fit a signed WIDTH-bit result when the bits from the
   // result sign bit upward are not all copies of one another.
   function automatic logic prod_ovf(input logic signed [PW-1:0] p);
      logic [WIDTH:0] top;
      top = p[PW-1:WIDTH-1];
      return !((&top) || !(|top));
   endfunction

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   // ---------------- control FSM: state register ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
   end

   // ---------------- control FSM: next state / result capture ----------------
   // A start pulse restarts from any state, which also drops an in-flight op.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      exc_d    = exc_q;
      load_mul = 1'b0;
      load_div = 1'b0;
      mul_step = 1'b0;
      div_step = 1'b0;
      if (ctrl_MULT) begin
         state_d  = ST_MUL;
         cnt_d    = '0;
         load_mul = 1'b1;
      end else if (ctrl_DIV) begin
         state_d  = ST_DIV;
         cnt_d    = '0;
         load_div = 1'b1;
      end else begin
         case (state_q)
            ST_MUL: begin
               mul_step = 1'b1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == MulLast) begin
                  state_d = ST_DONE;
                  res_d   = prod_next[WIDTH-1:0];
                  exc_d   = prod_ovf(prod_next);
               end
            end
            ST_DIV: begin
               if (div_zero_q) begin
                  state_d = ST_DONE;
                  res_d   = '0;
                  exc_d   = 1'b1;
               end else begin
                  div_step = 1'b1;
                  cnt_d    = cnt_q + 1'b1;
                  if (cnt_q == DivLast) begin
                     state_d = ST_DONE;
                     res_d   = sign_diff_q ? -quot_mag : quot_mag;
                     exc_d   = div_ovf_q;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------- multiply datapath ----------------
`ifdef MULTDIV_RADIX4_EN
   // Booth digit from bits {b[2i+1], b[2i], b[2i-1]}; shifting the multiplier
   // arithmetically keeps the top digit correct for negative multipliers.
   always_comb begin
      case (mplier_q[2:0])
         3'b001, 3'b010: addend = mcand_q;
         3'b011:         addend = mcand_q <<< 1;
         3'b100:         addend = -(mcand_q <<< 1);
         3'b101, 3'b110: addend = -mcand_q;
         default:        addend = '0;
      endcase
      prod_next = acc_q + addend;
   end

   always_ff @(posedge clock) begin
      if (load_mul) begin
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
         mplier_q <= {data_operandB, 1'b0};
      end else if (mul_step) begin
         acc_q    <= prod_next;
         mcand_q  <= mcand_q <<< 2;
         mplier_q <= {{2{mplier_q[MW-1]}}, mplier_q[MW-1:2]};
      end
   end
`else
   // The multiplier MSB carries negative weight in two's complement, so the
   // last partial product is subtracted rather than added.
   always_comb begin
      if (mplier_q[0]) addend = (cnt_q == MulLast) ? -mcand_q : mcand_q;
      else             addend = '0;
      prod_next = acc_q + addend;
   end

   always_ff @(posedge clock) begin
      if (load_mul) begin
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
         mplier_q <= data_operandB;
      end else if (mul_step) begin
         acc_q    <= prod_next;
         mcand_q  <= mcand_q <<< 1;
         mplier_q <= mplier_q >> 1;
      end
   end
`endif

   // ---------------- divide operand conditioning ----------------
   always_ff @(posedge clock) begin
      if (load_div) begin
         sign_diff_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         div_zero_q  <= (data_operandB == '0);
         div_ovf_q   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (&data_operandB);
      end
   end

   multdiv_div_core #(
      .WIDTH(WIDTH)
   ) u_div_core (
      .clk_i       (clock),
      .load_i      (load_div),
      .step_i      (div_step),
      .dividend_i  (magnitude(data_operandA)),
      .divisor_i   (magnitude(data_operandB)),
      .quot_next_o (quot_mag)
   );

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == ST_DONE);
   assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;

   localparam int W = 32;
`ifdef MULTDIV_RADIX4_EN
   localparam int MUL_LAT = W / 2 + 1;
`else
   localparam int MUL_LAT = W + 1;
`endif
   localparam int DIV_LAT = W + 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          ctrl_MULT = 1'b0;
   logic          ctrl_DIV = 1'b0;
   logic [W-1:0]  opA = '0;
   logic [W-1:0]  opB = '0;
   logic [W-1:0]  data_result;
   logic          data_exception;
   logic          data_resultRDY;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   multdiv_unit #(.WIDTH(W)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (opA),
      .data_operandB  (opB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   // Reference: signed arithmetic on 64-bit integers.
   function automatic void model(input logic mul, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic e, output int lat);
      longint p, q;
      longint maxv, minv;
      maxv = 64'sd2147483647;
      minv = -64'sd2147483648;
      if (mul) begin
         p   = longint'($signed(a)) * longint'($signed(b));
         r   = p[W-1:0];
         e   = (p > maxv) || (p < minv);
         lat = MUL_LAT;
      end else if (b == '0) begin
         r   = '0;
         e   = 1'b1;
         lat = 2;
      end else begin
         q   = longint'($signed(a)) / longint'($signed(b));
         r   = q[W-1:0];
         e   = (q > maxv);
         lat = DIV_LAT;
      end
   endfunction

   // Issue one operation and observe it; k counts cycles after the start cycle.
   task automatic do_op(input logic mul, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic exc, output int lat,
                        output int busy_bad, output int tail_bad);
      @(negedge clock);
      ctrl_MULT = mul;
      ctrl_DIV  = !mul;
      opA = a;
      opB = b;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      opA = $urandom;
      opB = $urandom;
      lat = -1;
      busy_bad = 0;
      tail_bad = 0;
      res = 'x;
      exc = 1'bx;
      for (int k = 1; k <= 100; k++) begin
         if (busy !== 1'b1) busy_bad++;
         if (data_resultRDY === 1'b1) begin
            lat = k;
            res = data_result;
            exc = data_exception;
            break;
         end
         @(negedge clock);
      end
      @(negedge clock);
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) tail_bad++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (data_result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", data_result); end
      checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exception got %b want 0", data_exception); end
      checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      // start pulse coincident with reset must be ignored
      ctrl_MULT = 1'b1;
      opA = 32'd7;
      opB = 32'd9;
      @(negedge clock);
      ctrl_MULT = 1'b0;
      reset = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < MUL_LAT + 4; k++) begin
            if (busy !== 1'b0 || data_resultRDY !== 1'b0) seen++;
            @(negedge clock);
         end
         checks++; if (seen != 0) begin errors++; $display("FAIL reset_priority active_cycles got %0d want 0", seen); end
      end
   endtask

   task automatic test_mul();
      logic [W-1:0] ta [4];
      logic [W-1:0] tb [4];
      logic [W-1:0] r, er;
      logic e, ee;
      int lat, elat, bb, tbad;
      ta[0] = 32'd7;        tb[0] = -32'sd6;
      ta[1] = 32'h00010000; tb[1] = 32'h00010000;
      ta[2] = 32'h80000000; tb[2] = 32'd1;
      ta[3] = 32'h80000000; tb[3] = 32'hFFFFFFFF;
      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] a, b;
         if (i < 4) begin a = ta[i]; b = tb[i]; end
         else if (i % 2 == 0) begin a = $urandom; b = $urandom; end
         else begin a = 32'($signed($urandom_range(0, 200)) - 100); b = 32'($signed($urandom_range(0, 200000)) - 100000); end
         model(1'b1, a, b, er, ee, elat);
         do_op(1'b1, a, b, r, e, lat, bb, tbad);
         checks++; if (r !== er) begin errors++; $display("FAIL mul_result a=%h b=%h got %h want %h", a, b, r, er); end
         checks++; if (e !== ee) begin errors++; $display("FAIL mul_exception a=%h b=%h got %b want %b", a, b, e, ee); end
         checks++; if (lat != elat) begin errors++; $display("FAIL mul_latency a=%h b=%h got %0d want %0d", a, b, lat, elat); end
         checks++; if (bb != 0 || tbad != 0) begin errors++; $display("FAIL mul_busy_pulse busy_low=%0d tail=%0d want 0 0", bb, tbad); end
      end
   endtask

   task automatic test_div();
      logic [W-1:0] ta [5];
      logic [W-1:0] tb [5];
      logic [W-1:0] r, er;
      logic e, ee;
      int lat, elat, bb, tbad;
      ta[0] = -32'sd100;    tb[0] = 32'd7;
      ta[1] = 32'd5;        tb[1] = 32'd0;
      ta[2] = 32'h80000000; tb[2] = 32'hFFFFFFFF;
      ta[3] = 32'h80000000; tb[3] = 32'd1;
      ta[4] = 32'd100;      tb[4] = -32'sd7;
      for (int i = 0; i < 25; i++) begin
         logic [W-1:0] a, b;
         if (i < 5) begin a = ta[i]; b = tb[i]; end
         else begin
            a = (i % 3 == 0) ? 32'($signed($urandom_range(0, 2000)) - 1000) : $urandom;
            case (i % 4)
               0: b = 32'($signed($urandom_range(0, 40)) - 20);
               1: b = $urandom;
               2: b = '0;
               default: b = 32'($signed($urandom_range(0, 2000000)) - 1000000);
            endcase
         end
         model(1'b0, a, b, er, ee, elat);
         do_op(1'b0, a, b, r, e, lat, bb, tbad);
         checks++; if (r !== er) begin errors++; $display("FAIL div_result a=%h b=%h got %h want %h", a, b, r, er); end
         checks++; if (e !== ee) begin errors++; $display("FAIL div_exception a=%h b=%h got %b want %b", a, b, e, ee); end
         checks++; if (lat != elat) begin errors++; $display("FAIL div_latency a=%h b=%h got %0d want %0d", a, b, lat, elat); end
         checks++; if (bb != 0 || tbad != 0) begin errors++; $display("FAIL div_busy_pulse busy_low=%0d tail=%0d want 0 0", bb, tbad); end
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] r, er;
      logic e, ee;
      int lat, elat, bb, tbad;
      model(1'b1, 32'h7FFFFFFF, 32'd3, er, ee, elat);
      do_op(1'b1, 32'h7FFFFFFF, 32'd3, r, e, lat, bb, tbad);
      repeat (5) @(negedge clock);
      checks++; if (data_result !== er) begin errors++; $display("FAIL hold_result got %h want %h", data_result, er); end
      checks++; if (data_exception !== ee) begin errors++; $display("FAIL hold_exception got %b want %b", data_exception, ee); end
   endtask

   task automatic test_restart();
      int rdy_cnt, first_rdy, busy_bad;
      logic [W-1:0] r;
      logic e;
      rdy_cnt = 0;
      first_rdy = -1;
      busy_bad = 0;
      r = 'x;
      e = 1'bx;
      @(negedge clock);
      ctrl_MULT = 1'b1;
      opA = 32'd3;
      opB = 32'd4;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clock);
         ctrl_MULT = 1'b0;
         ctrl_DIV  = (k == 10);
         if (k == 10) begin opA = 32'd20; opB = 32'd5; end
         else begin opA = $urandom; opB = $urandom; end
         if (k <= 10 + DIV_LAT && busy !== 1'b1) busy_bad++;
         if (data_resultRDY === 1'b1) begin
            rdy_cnt++;
            if (first_rdy < 0) begin first_rdy = k; r = data_result; e = data_exception; end
         end
      end
      checks++; if (rdy_cnt != 1) begin errors++; $display("FAIL restart_pulses got %0d want 1", rdy_cnt); end
      checks++; if (first_rdy != 10 + DIV_LAT) begin errors++; $display("FAIL restart_latency got %0d want %0d", first_rdy, 10 + DIV_LAT); end
      checks++; if (r !== 32'd4 || e !== 1'b0) begin errors++; $display("FAIL restart_result got %h/%b want 00000004/0", r, e); end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL restart_busy low_cycles got %0d want 0", busy_bad); end
   endtask

   task automatic test_reset_midop();
      int bad;
      logic [W-1:0] r;
      logic e;
      int lat, bb, tbad;
      bad = 0;
      // leave a non-zero result behind so the clear is visible
      do_op(1'b0, 32'd1000, 32'd3, r, e, lat, bb, tbad);
      @(negedge clock);
      ctrl_DIV = 1'b1;
      opA = -32'sd100;
      opB = 32'd7;
      for (int k = 1; k <= DIV_LAT + 10; k++) begin
         @(negedge clock);
         ctrl_DIV = 1'b0;
         reset = (k == 5);
         if (k >= 6 && (data_result !== '0 || data_exception !== 1'b0 ||
                        data_resultRDY !== 1'b0 || busy !== 1'b0)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL midop_reset nonzero_cycles got %0d want 0", bad); end
      do_op(1'b1, 32'd2, 32'd3, r, e, lat, bb, tbad);
      checks++; if (r !== 32'd6 || e !== 1'b0) begin errors++; $display("FAIL after_reset_mul got %h/%b want 00000006/0", r, e); end
      checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL after_reset_latency got %0d want %0d", lat, MUL_LAT); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] r, er;
      logic e, ee;
      int lat, elat, bb, tbad;
      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] a, b;
         logic m;
         m = i[0];
         a = $urandom;
         b = (i % 3 == 0) ? 32'd0 : $urandom;
         model(m, a, b, er, ee, elat);
         do_op(m, a, b, r, e, lat, bb, tbad);
         checks++; if (r !== er || e !== ee || lat != elat) begin
            errors++;
            $display("FAIL b2b mul=%b a=%h b=%h got %h/%b/%0d want %h/%b/%0d", m, a, b, r, e, lat, er, ee, elat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_hold();
      test_restart();
      test_reset_midop();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
